// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state encoding and add/sub opcode constants
package alu_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/ful_add_beh.sv
// ful_add_beh: 1-bit full-adder cell
// Ports: a, b, ci -> s (sum), co (carry out)
module ful_add_beh (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_sub_ctrl.sv
// serial_add_sub_ctrl: bit-serial WIDTH-bit adder/subtractor sharing one full-adder cell, LSB first
// Ports: CLK, RST_N (sync, active-low), START/SUB/A/B request, READY/BUSY/DONE handshake,
//        S/COUT/OVF registered result. Optional ABORT input with SERIAL_ADD_SUB_ABORT_EN.
module serial_add_sub_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_ABORT_EN
    input  logic             ABORT,
`endif
    output logic             READY,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF
);
    localparam int CW = $clog2(WIDTH) + 1;
    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic [CW-1:0]    cnt;
    logic             carry, sum, co, abort, last;
`ifdef SERIAL_ADD_SUB_ABORT_EN
    assign abort = ABORT;
`else
    assign abort = 1'b0;
`endif
    assign last = cnt == CW'(WIDTH - 1);
    ful_add_beh u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (sum),
        .co (co)
    );
    // Results are committed on the last RUN edge so they are already valid
    // during the FIN cycle in which DONE is high; carry at that edge is the
    // carry into the MSB, which gives the signed-overflow flag.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            READY <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            S     <= '0;
            COUT  <= 1'b0;
            OVF   <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: if (START) begin
                    a_sh  <= A;
                    b_sh  <= (SUB == OP_ADD) ? B : ~B;
                    carry <= SUB == OP_SUB;
                    s_sh  <= '0;
                    cnt   <= '0;
                    state <= RUN;
                    READY <= 1'b0;
                    BUSY  <= 1'b1;
                end
                RUN: if (abort) begin
                    a_sh  <= '0;
                    b_sh  <= '0;
                    s_sh  <= '0;
                    carry <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                    READY <= 1'b1;
                    BUSY  <= 1'b0;
                end else begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= {sum, s_sh[WIDTH-1:1]};
                    carry <= co;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        S     <= {sum, s_sh[WIDTH-1:1]};
                        COUT  <= co;
                        OVF   <= carry ^ co;
                        DONE  <= 1'b1;
                        state <= FIN;
                    end
                end
                default: begin
                    state <= IDLE;
                    READY <= 1'b1;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// tb_serial_add_sub_ctrl: randomized self-checking bench with behavioural model and literal pins
module tb_serial_add_sub_ctrl;
    localparam int W = 8;
    logic         clk = 0, rst_n = 0, start = 0, sub = 0, abort = 0, chk_en = 0;
    logic [W-1:0] a = 0, b = 0, s;
    logic         ready, busy, done, cout, ovf;
    int           checks = 0, errors = 0;

    serial_add_sub_ctrl #(.WIDTH(W)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .SUB(sub), .A(a), .B(b),
`ifdef SERIAL_ADD_SUB_ABORT_EN
        .ABORT(abort),
`endif
        .READY(ready), .BUSY(busy), .DONE(done), .S(s), .COUT(cout), .OVF(ovf)
    );

    always #5 clk = ~clk;

    // Model: phase 0 = idle, 1..W = bit cycles, W+1 = result cycle.
    int           phase = 0;
    logic [W-1:0] m_s = 0, p_s = 0;
    logic         m_c = 0, m_o = 0, p_c = 0, p_o = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            phase = 0; m_s = 0; m_c = 0; m_o = 0;
        end else if (phase == 0) begin
            if (start) begin
                int ua, ub, sa, sb, r, sr;
                ua = int'(a); ub = int'(b);
                sa = ua >= (1 << (W-1)) ? ua - (1 << W) : ua;
                sb = ub >= (1 << (W-1)) ? ub - (1 << W) : ub;
                r  = sub ? ua - ub : ua + ub;
                sr = sub ? sa - sb : sa + sb;
                p_s = W'(r);
                p_c = sub ? (ua >= ub) : (r >= (1 << W));
                p_o = (sr >= (1 << (W-1))) || (sr < -(1 << (W-1)));
                phase = 1;
            end
        end else if (abort && phase <= W) phase = 0;
        else if (phase == W + 1) phase = 0;
        else begin
            phase++;
            if (phase == W + 1) begin m_s = p_s; m_c = p_c; m_o = p_o; end
        end
    end

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("m_ready", ready, phase == 0);
        chk("m_busy", busy, phase != 0);
        chk("m_done", done, phase == W + 1);
        chk("m_s", s, m_s);
        chk("m_cout", cout, m_c);
        chk("m_ovf", ovf, m_o);
    end

    task automatic op(input logic [W-1:0] ia, ib, input logic isub,
                      input logic [W-1:0] es, input logic ec, eo);
        int n = 1;
        a = ia; b = ib; sub = isub; start = 1;
        @(negedge clk); start = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        chk("lat", n, W + 1);
        chk("op_s", s, es);
        chk("op_cout", cout, ec);
        chk("op_ovf", ovf, eo);
        @(negedge clk);
        chk("op_ready_after", ready, 1);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 40) begin @(negedge clk); n++; end
        chk("wait_ready", ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int ndone, t1, t2;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_s", s, 0); chk("rst_cout", cout, 0); chk("rst_ovf", ovf, 0);
        rst_n = 1; chk_en = 1;
        @(negedge clk);
        op(100, 27, 0, 127, 0, 0);
        op(200, 100, 0, 44, 1, 0);
        op(127, 1, 0, 8'h80, 0, 1);
        op(5, 7, 1, 8'hFE, 0, 0);
        op(8'h80, 1, 1, 8'h7F, 1, 1);
        // START during RUN is ignored
        a = 100; b = 27; sub = 0; start = 1;
        @(negedge clk); start = 0;
        repeat (2) @(negedge clk);
        a = 1; b = 1; start = 1;
        @(negedge clk); start = 0;
        ndone = 0;
        repeat (20) begin @(negedge clk); if (done) ndone++; end
        chk("ign_ndone", ndone, 1);
        chk("ign_s", s, 127);
        // START held high: back-to-back operations
        a = 200; b = 100; sub = 0; start = 1;
        t1 = -1; t2 = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) begin if (t1 < 0) t1 = c; else if (t2 < 0) t2 = c; end
        end
        start = 0;
        chk("b2b_spacing", t2 - t1, W + 2);
        wait_ready();
        @(negedge clk);
        // reset in the middle of RUN
        a = 127; b = 1; sub = 0; start = 1;
        @(negedge clk); start = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        @(negedge clk); rst_n = 1;
        chk("mid_rst_ready", ready, 1); chk("mid_rst_s", s, 0);
        chk("mid_rst_cout", cout, 0); chk("mid_rst_ovf", ovf, 0); chk("mid_rst_done", done, 0);
        ndone = 0;
        repeat (12) begin @(negedge clk); if (done) ndone++; end
        chk("mid_rst_ndone", ndone, 0);
`ifdef SERIAL_ADD_SUB_ABORT_EN
        op(100, 27, 0, 127, 0, 0);
        a = 5; b = 7; sub = 1; start = 1;
        @(negedge clk); start = 0;
        repeat (3) @(negedge clk);
        abort = 1;
        @(negedge clk); abort = 0;
        chk("abort_ready", ready, 1);
        ndone = 0;
        repeat (12) begin @(negedge clk); if (done) ndone++; end
        chk("abort_ndone", ndone, 0);
        chk("abort_s", s, 127);
`endif
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 2) == 0);
            sub   = $urandom_range(0, 1);
            a     = W'($urandom);
            b     = W'($urandom);
`ifdef SERIAL_ADD_SUB_ABORT_EN
            abort = ($urandom_range(0, 24) == 0);
`endif
            rst_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        start = 0; abort = 0; rst_n = 1;
        wait_ready();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
